// File: rtl/sprite_pkg.sv
// Shared constants and response-pipeline stage type for the sprite ROM arbiter.
// Optional feature macro used by the arbiter: SPRITE_ARB_FIXED_PRIO_EN.
package sprite_pkg;

    localparam int SPRITE_AW     = 9;
    localparam int SPRITE_DW     = 8;
    localparam int SPRITE_PIXELS = 400;
    localparam logic [7:0] OOR_FILL = 8'd255;

    // Wide enough to tag any of up to 8 requesters.
    localparam int ID_W = 3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            oor;
    } rsp_stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant generator that owns the last-granted pointer.
// With SPRITE_ARB_FIXED_PRIO_EN defined, requester 0 always wins and the rest rotate.
module rr_arbiter
    import sprite_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [NREQ-1:0] req,
    input  logic            update,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx
);

    logic [ID_W-1:0] last;
    logic            found;
    int              idx;

    // Search begins just after the previous winner and wraps around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        if (req[0]) begin
            grant[0] = 1'b1;
            found    = 1'b1;
        end
`endif
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last) + k;
            if (idx >= NREQ) idx = idx - NREQ;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
            if (!found && idx != 0 && req[idx]) begin
`else
            if (!found && req[idx]) begin
`endif
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last <= ID_W'(NREQ - 1);
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        end else if (update && grant_idx != '0) begin
`else
        end else if (update) begin
`endif
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous-read sprite ROM among NREQ requesters with tagged fixed-latency responses.
// Define SPRITE_ARB_FIXED_PRIO_EN to give requester 0 absolute priority.
module sprite_rom_arbiter #(
    parameter int NREQ          = 4,
    parameter int AW            = sprite_pkg::SPRITE_AW,
    parameter int DW            = sprite_pkg::SPRITE_DW,
    parameter int ROM_LAT       = 1,
    parameter int SPRITE_PIXELS = sprite_pkg::SPRITE_PIXELS,
    parameter logic [DW-1:0] OOR_FILL = DW'(sprite_pkg::OOR_FILL)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    req_ready,
    output logic [AW-1:0]      rom_address,
    input  logic [DW-1:0]      rom_q,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic [7:0]         oor_count,
    output logic               busy
);

    import sprite_pkg::*;

    localparam logic [AW:0] PIX_LIM = (AW+1)'(SPRITE_PIXELS);

    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_idx;
    logic            accept;
    logic [AW-1:0]   sel_addr;
    logic            sel_oor;
    rsp_stage_t      pipe [ROM_LAT];
    rsp_stage_t      tail;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clock     (clock),
        .resetn    (resetn),
        .req       (req_valid),
        .update    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |(grant & req_valid);
    assign sel_addr  = req_addr[grant_idx*AW +: AW];
    assign sel_oor   = {1'b0, sel_addr} >= PIX_LIM;
    // Out-of-range reads park the ROM at address 0 rather than aliasing into the bitmap.
    assign rom_address = (accept && !sel_oor) ? sel_addr : '0;
    assign tail        = pipe[ROM_LAT-1];

    // Tag pipeline tracks each read until its ROM data emerges.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < ROM_LAT; s++) pipe[s] <= '0;
        end else begin
            pipe[0] <= {accept, grant_idx, sel_oor};
            for (int s = 1; s < ROM_LAT; s++) pipe[s] <= pipe[s-1];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (tail.valid) begin
            rsp_valid <= NREQ'(1) << tail.id;
            rsp_data  <= tail.oor ? OOR_FILL : rom_q;
        end else begin
            rsp_valid <= '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            oor_count <= '0;
        end else if (accept && sel_oor && oor_count != 8'hFF) begin
            oor_count <= oor_count + 8'd1;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < ROM_LAT; s++) busy = busy | pipe[s].valid;
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomised self-checking bench for sprite_rom_arbiter against a queue-based reference model.
// Honours SPRITE_ARB_FIXED_PRIO_EN when the same macro is defined for the build.
module tb_sprite_rom_arbiter;

    localparam int NREQ    = 4;
    localparam int AW      = 9;
    localparam int DW      = 8;
    localparam int ROM_LAT = 1;
    localparam int PIXELS  = 400;

    logic               clock = 1'b0;
    logic               resetn;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic [AW-1:0]      rom_address;
    logic [DW-1:0]      rom_q;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic [7:0]         oor_count;
    logic               busy;

    sprite_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(ROM_LAT)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .oor_count   (oor_count),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // Sprite bitmap stand-in: the known rom_cai_b pixels, arbitrary filler elsewhere.
    function automatic logic [7:0] rom_val(input int a);
        if (a == 0) return 8'd255;
        if (a == 9 || (a >= 28 && a <= 31)) return 8'd204;
        return 8'((a * 37 + 11) & 255);
    endfunction

    logic [7:0] rom_mem [512];
    initial for (int i = 0; i < 512; i++) rom_mem[i] = rom_val(i);
    always @(posedge clock) rom_q <= rom_mem[rom_address];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t            m_q[$];
    int              m_last;
    int              m_cyc;
    int              m_oor;
    logic [NREQ-1:0] exp_ready, obs_ready, exp_rsp_valid, obs_rsp_valid;
    logic [AW-1:0]   exp_addr, obs_addr;
    logic [7:0]      exp_data, obs_data, exp_oor, obs_oor;
    logic            exp_busy, obs_busy;

    task automatic model_reset();
        m_last = NREQ - 1;
        m_q.delete();
        m_cyc = 0;
        m_oor = 0;
        exp_rsp_valid = '0;
        exp_data = '0;
        exp_oor = '0;
        exp_busy = 1'b0;
    endtask

    // Winner is the valid requester at the smallest ring distance past the previous winner.
    function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v);
        int best, bestd, d;
        best = -1;
        bestd = NREQ + 1;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        if (v[0]) return NREQ'(1);
`endif
        for (int i = 0; i < NREQ; i++) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
            if (i == 0) continue;
`endif
            if (v[i]) begin
                d = (i - m_last - 1 + 2 * NREQ) % NREQ;
                if (d < bestd) begin
                    bestd = d;
                    best = i;
                end
            end
        end
        return (best < 0) ? '0 : (NREQ'(1) << best);
    endfunction

    // One clock of stimulus; samples combinational outputs before the edge and registered ones after.
    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a);
        int gi, ad;
        req_valid = v;
        req_addr = a;
        #1;
        exp_ready = model_grant(v);
        gi = -1;
        for (int i = 0; i < NREQ; i++) if (exp_ready[i]) gi = i;
        ad = (gi >= 0) ? int'(a[gi*AW +: AW]) : 0;
        exp_addr = (gi >= 0 && ad < PIXELS) ? AW'(ad) : '0;
        obs_ready = req_ready;
        obs_addr = rom_address;
        @(posedge clock);
        m_cyc++;
        exp_rsp_valid = '0;
        if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
            exp_rsp_valid = NREQ'(1) << m_q[0].id;
            exp_data = m_q[0].data;
            void'(m_q.pop_front());
        end
        if (gi >= 0) begin
            m_q.push_back('{gi, (ad < PIXELS) ? rom_val(ad) : 8'd255, m_cyc + ROM_LAT});
            if (ad >= PIXELS && m_oor < 255) m_oor++;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
            if (gi != 0) m_last = gi;
`else
            m_last = gi;
`endif
        end
        exp_oor = 8'(m_oor);
        exp_busy = (m_q.size() != 0);
        #1;
        obs_rsp_valid = rsp_valid;
        obs_data = rsp_data;
        obs_oor = oor_count;
        obs_busy = busy;
    endtask

    function automatic logic [NREQ*AW-1:0] pack_all(input int a);
        logic [NREQ*AW-1:0] r;
        for (int i = 0; i < NREQ; i++) r[i*AW +: AW] = AW'(a);
        return r;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        req_valid = '0;
        req_addr = '0;
        repeat (2) @(posedge clock);
        #1;
        vectors++; if (req_ready !== '0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 0", req_ready); end
        vectors++; if (rsp_valid !== '0) begin miscompares++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        vectors++; if (rsp_data !== '0) begin miscompares++; $display("[TB] FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        vectors++; if (oor_count !== '0) begin miscompares++; $display("[TB] FAIL reset_oor_count: got %0d expected 0", oor_count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int c = 0; c < 6; c++) begin
            applyStimulus((c < 5) ? 4'b1111 : 4'b0000, pack_all(0));
            vectors++; if (obs_ready !== exp_ready) begin miscompares++; $display("[TB] FAIL rr_ready: got %b expected %b", obs_ready, exp_ready); end
`ifndef SPRITE_ARB_FIXED_PRIO_EN
            if (c < 5) begin
                vectors++; if (obs_ready !== seq[c]) begin miscompares++; $display("[TB] FAIL rr_sequence: got %b expected %b", obs_ready, seq[c]); end
            end
`endif
            vectors++; if (obs_rsp_valid !== exp_rsp_valid) begin miscompares++; $display("[TB] FAIL rr_rsp_valid: got %b expected %b", obs_rsp_valid, exp_rsp_valid); end
            vectors++; if (obs_data !== exp_data) begin miscompares++; $display("[TB] FAIL rr_rsp_data: got %0d expected %0d", obs_data, exp_data); end
        end
    endtask

    task automatic test_single();
        applyStimulus(4'b0001, pack_all(9));
        vectors++; if (obs_addr !== 9'd9) begin miscompares++; $display("[TB] FAIL single_rom_address: got %0d expected 9", obs_addr); end
        vectors++; if (obs_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL single_ready: got %b expected 0001", obs_ready); end
        applyStimulus(4'b0000, pack_all(0));
        vectors++; if (obs_rsp_valid !== 4'b0001) begin miscompares++; $display("[TB] FAIL single_rsp_valid: got %b expected 0001", obs_rsp_valid); end
        vectors++; if (obs_data !== 8'd204) begin miscompares++; $display("[TB] FAIL single_rsp_data: got %0d expected 204", obs_data); end
        applyStimulus(4'b0000, pack_all(0));
        vectors++; if (obs_rsp_valid !== 4'b0000 || obs_data !== 8'd204) begin miscompares++; $display("[TB] FAIL single_hold: got %b/%0d expected 0000/204", obs_rsp_valid, obs_data); end
    endtask

    task automatic test_oor();
        for (int c = 0; c < 300; c++) begin
            applyStimulus(4'b0100, pack_all(450));
            vectors++; if (obs_addr !== exp_addr) begin miscompares++; $display("[TB] FAIL oor_rom_address: got %0d expected %0d", obs_addr, exp_addr); end
            vectors++; if (obs_oor !== exp_oor) begin miscompares++; $display("[TB] FAIL oor_count: got %0d expected %0d", obs_oor, exp_oor); end
            if (c == 1) begin
                vectors++; if (obs_rsp_valid !== 4'b0100 || obs_data !== 8'd255) begin miscompares++; $display("[TB] FAIL oor_rsp: got %b/%0d expected 0100/255", obs_rsp_valid, obs_data); end
            end
        end
        applyStimulus(4'b0000, pack_all(0));
        vectors++; if (obs_oor !== 8'd255) begin miscompares++; $display("[TB] FAIL oor_saturate: got %0d expected 255", obs_oor); end
    endtask

    task automatic test_reset_midflight();
        applyStimulus(4'b0010, pack_all(5));
        vectors++; if (obs_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_busy_before: got %b expected 1", obs_busy); end
        req_valid = '0;
        #1 resetn = 1'b0;
        #3 resetn = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        vectors++; if (rsp_valid !== '0) begin miscompares++; $display("[TB] FAIL mid_rsp_valid: got %b expected 0", rsp_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
        applyStimulus(4'b1111, pack_all(3));
        vectors++; if (obs_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL mid_first_grant: got %b expected 0001", obs_ready); end
        applyStimulus(4'b0000, pack_all(0));
        vectors++; if (obs_rsp_valid !== 4'b0001) begin miscompares++; $display("[TB] FAIL mid_first_rsp: got %b expected 0001", obs_rsp_valid); end
    endtask

    task automatic test_two_req();
        logic [NREQ-1:0] prev;
        prev = '0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(4'b0011, pack_all(c));
            vectors++; if (obs_ready !== exp_ready) begin miscompares++; $display("[TB] FAIL two_ready: got %b expected %b", obs_ready, exp_ready); end
`ifdef SPRITE_ARB_FIXED_PRIO_EN
            vectors++; if (obs_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL two_fixed: got %b expected 0001", obs_ready); end
`else
            if (c > 0) begin
                vectors++; if (obs_ready === prev) begin miscompares++; $display("[TB] FAIL two_alternate: got %b expected not %b", obs_ready, prev); end
            end
`endif
            prev = obs_ready;
        end
        applyStimulus(4'b0000, pack_all(0));
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 5; c++) begin
            applyStimulus((c < 4) ? 4'b1000 : 4'b0000, pack_all(28 + c));
            if (c < 4) begin
                vectors++; if (obs_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_busy: got %b expected 1", obs_busy); end
            end
            if (c > 0) begin
                vectors++; if (obs_rsp_valid !== 4'b1000 || obs_data !== 8'd204) begin miscompares++; $display("[TB] FAIL b2b_rsp: got %b/%0d expected 1000/204", obs_rsp_valid, obs_data); end
            end
        end
        applyStimulus(4'b0000, pack_all(0));
        vectors++; if (obs_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_idle_busy: got %b expected 0", obs_busy); end
    endtask

    task automatic test_random();
        logic [NREQ*AW-1:0] a;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) a[i*AW +: AW] = AW'($urandom_range(0, 511));
            applyStimulus(NREQ'($urandom_range(0, 15)), a);
            vectors++; if (obs_ready !== exp_ready) begin miscompares++; $display("[TB] FAIL rand_ready: got %b expected %b", obs_ready, exp_ready); end
            vectors++; if (obs_addr !== exp_addr) begin miscompares++; $display("[TB] FAIL rand_rom_address: got %0d expected %0d", obs_addr, exp_addr); end
            vectors++; if (obs_rsp_valid !== exp_rsp_valid) begin miscompares++; $display("[TB] FAIL rand_rsp_valid: got %b expected %b", obs_rsp_valid, exp_rsp_valid); end
            vectors++; if (obs_data !== exp_data) begin miscompares++; $display("[TB] FAIL rand_rsp_data: got %0d expected %0d", obs_data, exp_data); end
            vectors++; if (obs_oor !== exp_oor) begin miscompares++; $display("[TB] FAIL rand_oor_count: got %0d expected %0d", obs_oor, exp_oor); end
            vectors++; if (obs_busy !== exp_busy) begin miscompares++; $display("[TB] FAIL rand_busy: got %b expected %b", obs_busy, exp_busy); end
        end
    endtask

    initial begin
        test_reset();
        @(posedge clock);
        #1;
        test_round_robin();
        test_single();
        test_oor();
        test_reset_midflight();
        test_two_req();
        test_back_to_back();
        test_reset();
        @(posedge clock);
        #1;
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
